// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: source indices, field widths and the queued payload.
package wb_arbiter_pkg;

    localparam int unsigned WB_NSRC   = 3;
    localparam int unsigned WB_REG_W  = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [1:0] {
        WB_SRC_AM = 2'd0,
        WB_SRC_MU = 2'd1,
        WB_SRC_LS = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [WB_REG_W-1:0]  regdest;
        logic [WB_DATA_W-1:0] wbvalue;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

    // Round-robin successor, modulo the three sources.
    function automatic wb_src_e wb_src_next(input wb_src_e src);
        case (src)
            WB_SRC_AM: return WB_SRC_MU;
            WB_SRC_MU: return WB_SRC_LS;
            default:   return WB_SRC_AM;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue; simultaneous push and pop are both honoured even when full.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges AluMisc/Mult/LoadStore results onto the single ARF write port via per-unit FIFOs and a round-robin arbiter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  am_wb_oper,
    input  logic                  am_wb_writereg,
    input  logic [WB_REG_W-1:0]   am_wb_regdest,
    input  logic [WB_DATA_W-1:0]  am_wb_wbvalue,
    input  logic                  mu_wb_oper,
    input  logic                  mu_wb_writereg,
    input  logic [WB_REG_W-1:0]   mu_wb_regdest,
    input  logic [WB_DATA_W-1:0]  mu_wb_wbvalue,
    input  logic                  ls_wb_oper,
    input  logic                  ls_wb_writereg,
    input  logic [WB_REG_W-1:0]   ls_wb_regdest,
    input  logic [WB_DATA_W-1:0]  ls_wb_wbvalue,
    output logic                  wb_rf_writeenable,
    output logic [WB_REG_W-1:0]   wb_rf_regdest,
    output logic [WB_DATA_W-1:0]  wb_rf_writedata,
    output logic                  wb_iss_stall,
    output logic                  wb_err_overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WB_NSRC-1:0] fifo_push;
    logic [WB_NSRC-1:0] fifo_pop;
    logic [WB_NSRC-1:0] fifo_empty;
    logic [WB_NSRC-1:0] fifo_full;
    logic [WB_NSRC-1:0] src_stall;
    logic [WB_NSRC-1:0] src_ovf;
    wb_entry_t          fifo_din   [WB_NSRC];
    wb_entry_t          fifo_dout  [WB_NSRC];
    logic [CNT_W-1:0]   fifo_count [WB_NSRC];

    wb_src_e              rr_ptr;
    wb_src_e              rr_ptr_d;
    wb_src_e              grant_src;
    wb_src_e              cand1;
    wb_src_e              cand2;
    logic                 grant_valid;
    logic                 writeenable_d;
    logic [WB_REG_W-1:0]  regdest_d;
    logic [WB_DATA_W-1:0] writedata_d;
    logic                 overflow_d;

    // Writes to $zero and non-writing ops never enter a queue.
    assign fifo_push[0] = am_wb_oper && am_wb_writereg && (am_wb_regdest != '0);
    assign fifo_push[1] = mu_wb_oper && mu_wb_writereg && (mu_wb_regdest != '0);
    assign fifo_push[2] = ls_wb_oper && ls_wb_writereg && (ls_wb_regdest != '0);

    assign fifo_din[0] = '{regdest: am_wb_regdest, wbvalue: am_wb_wbvalue};
    assign fifo_din[1] = '{regdest: mu_wb_regdest, wbvalue: mu_wb_wbvalue};
    assign fifo_din[2] = '{regdest: ls_wb_regdest, wbvalue: ls_wb_wbvalue};

    for (genvar g = 0; g < WB_NSRC; g++) begin : g_src
        wb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WB_ENTRY_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (fifo_din[g]),
            .dout  (fifo_dout[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g]),
            .count (fifo_count[g])
        );

        // One slot of margin for an op issued during the stall cycle itself.
        assign src_stall[g] = (fifo_count[g] >= CNT_W'(DEPTH - 1));
        assign src_ovf[g]   = fifo_push[g] && fifo_full[g] && !fifo_pop[g];
    end

    assign wb_iss_stall = |src_stall;

    // Round-robin grant: first non-empty queue at or after the pointer.
    always_comb begin
        cand1       = wb_src_next(rr_ptr);
        cand2       = wb_src_next(cand1);
        grant_valid = 1'b1;
        grant_src   = rr_ptr;
        fifo_pop    = '0;
        if (!fifo_empty[rr_ptr]) begin
            grant_src = rr_ptr;
        end else if (!fifo_empty[cand1]) begin
            grant_src = cand1;
        end else if (!fifo_empty[cand2]) begin
            grant_src = cand2;
        end else begin
            grant_valid = 1'b0;
        end
        if (grant_valid) fifo_pop[grant_src] = 1'b1;
    end

    always_comb begin
        writeenable_d = grant_valid;
        regdest_d     = wb_rf_regdest;
        writedata_d   = wb_rf_writedata;
        rr_ptr_d      = rr_ptr;
        overflow_d    = wb_err_overflow || (|src_ovf);
        if (grant_valid) begin
            regdest_d   = fifo_dout[grant_src].regdest;
            writedata_d = fifo_dout[grant_src].wbvalue;
            rr_ptr_d    = wb_src_next(grant_src);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_rf_writeenable <= 1'b0;
            wb_rf_regdest     <= '0;
            wb_rf_writedata   <= '0;
            wb_err_overflow   <= 1'b0;
            rr_ptr            <= WB_SRC_AM;
        end else begin
            wb_rf_writeenable <= writeenable_d;
            wb_rf_regdest     <= regdest_d;
            wb_rf_writedata   <= writedata_d;
            wb_err_overflow   <= overflow_d;
            rr_ptr            <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, stall, overflow and mid-run reset.
module tb_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        am_wb_oper, am_wb_writereg;
    logic [4:0]  am_wb_regdest;
    logic [31:0] am_wb_wbvalue;
    logic        mu_wb_oper, mu_wb_writereg;
    logic [4:0]  mu_wb_regdest;
    logic [31:0] mu_wb_wbvalue;
    logic        ls_wb_oper, ls_wb_writereg;
    logic [4:0]  ls_wb_regdest;
    logic [31:0] ls_wb_wbvalue;
    logic        wb_rf_writeenable;
    logic [4:0]  wb_rf_regdest;
    logic [31:0] wb_rf_writedata;
    logic        wb_iss_stall;
    logic        wb_err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .am_wb_oper        (am_wb_oper),
        .am_wb_writereg    (am_wb_writereg),
        .am_wb_regdest     (am_wb_regdest),
        .am_wb_wbvalue     (am_wb_wbvalue),
        .mu_wb_oper        (mu_wb_oper),
        .mu_wb_writereg    (mu_wb_writereg),
        .mu_wb_regdest     (mu_wb_regdest),
        .mu_wb_wbvalue     (mu_wb_wbvalue),
        .ls_wb_oper        (ls_wb_oper),
        .ls_wb_writereg    (ls_wb_writereg),
        .ls_wb_regdest     (ls_wb_regdest),
        .ls_wb_wbvalue     (ls_wb_wbvalue),
        .wb_rf_writeenable (wb_rf_writeenable),
        .wb_rf_regdest     (wb_rf_regdest),
        .wb_rf_writedata   (wb_rf_writedata),
        .wb_iss_stall      (wb_iss_stall),
        .wb_err_overflow   (wb_err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-computed write orders (regdest) for the contention scenarios.
    logic [2:0] s3_en  [4]  = '{3'b111, 3'b101, 3'b001, 3'b001};
    logic [4:0] s3_am  [4]  = '{5'd4, 5'd5, 5'd6, 5'd7};
    logic [4:0] s3_ls  [4]  = '{5'd8, 5'd9, 5'd0, 5'd0};
    logic [4:0] s3_exp [7]  = '{5'd4, 5'd13, 5'd8, 5'd5, 5'd9, 5'd6, 5'd7};
    logic [4:0] s5_exp [12] = '{5'd16, 5'd24, 5'd10, 5'd17, 5'd25, 5'd11,
                                5'd18, 5'd26, 5'd12, 5'd19, 5'd20, 5'd21};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] val(input logic [4:0] r);
        return 32'hD00D_0000 | {27'd0, r};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] en, input logic [4:0] ra, input logic [4:0] rm,
                         input logic [4:0] rl);
        am_wb_oper = en[0]; am_wb_writereg = en[0]; am_wb_regdest = ra; am_wb_wbvalue = val(ra);
        mu_wb_oper = en[1]; mu_wb_writereg = en[1]; mu_wb_regdest = rm; mu_wb_wbvalue = val(rm);
        ls_wb_oper = en[2]; ls_wb_writereg = en[2]; ls_wb_regdest = rl; ls_wb_wbvalue = val(rl);
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] r);
        check({tag, ".we"}, 32'(wb_rf_writeenable), 32'd1);
        check({tag, ".rd"}, 32'(wb_rf_regdest), 32'(r));
        check({tag, ".wd"}, wb_rf_writedata, val(r));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".we"}, 32'(wb_rf_writeenable), 32'd0);
    endtask

    task automatic single_am_push(input string tag);
        drive(3'b001, 5'd5, 5'd0, 5'd0);
        am_wb_wbvalue = 32'h1234_5678;
        step();
        expect_idle({tag, ".t"});
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        check({tag, ".we1"}, 32'(wb_rf_writeenable), 32'd1);
        check({tag, ".rd1"}, 32'(wb_rf_regdest), 32'd5);
        check({tag, ".wd1"}, wb_rf_writedata, 32'h1234_5678);
        step();
        check({tag, ".we2"}, 32'(wb_rf_writeenable), 32'd0);
        check({tag, ".rd2"}, 32'(wb_rf_regdest), 32'd5);
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        step();
        check("rst.we",  32'(wb_rf_writeenable), 32'd0);
        check("rst.rd",  32'(wb_rf_regdest), 32'd0);
        check("rst.wd",  wb_rf_writedata, 32'd0);
        check("rst.stl", 32'(wb_iss_stall), 32'd0);
        check("rst.ovf", 32'(wb_err_overflow), 32'd0);
        reset = 1'b1;
        step();

        // Single push: strobe one cycle after the enqueue edge.
        single_am_push("s1");

        // Realign pointer to am with a lone ls write.
        drive(3'b100, 5'd0, 5'd0, 5'd9);
        step();
        expect_idle("s1b.t");
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        expect_wr("s1b", 5'd9);
        step();
        expect_idle("s1b.end");

        // Three simultaneous pushes drain in am, mu, ls order.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(3'b111, 5'd1, 5'd2, 5'd3);
            else        drive(3'b000, 5'd0, 5'd0, 5'd0);
            step();
            if (k >= 1 && k <= 3) expect_wr($sformatf("s2_k%0d", k), 5'(k));
            else                  expect_idle($sformatf("s2_k%0d", k));
        end

        // am burst against ls backlog; am count reaches 3 once.
        for (int k = 0; k < 9; k++) begin
            if (k < 4) drive(s3_en[k], s3_am[k], 5'd13, s3_ls[k]);
            else       drive(3'b000, 5'd0, 5'd0, 5'd0);
            step();
            if (k >= 1 && k <= 7) expect_wr($sformatf("s3_k%0d", k), s3_exp[k-1]);
            else                  expect_idle($sformatf("s3_k%0d", k));
            check($sformatf("s3_stall_k%0d", k), 32'(wb_iss_stall), (k == 3) ? 32'd1 : 32'd0);
        end
        check("s3.ovf", 32'(wb_err_overflow), 32'd0);

        // Non-writing ops and $zero writes are ignored.
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        am_wb_oper = 1'b1; am_wb_writereg = 1'b0; am_wb_regdest = 5'd8;
        mu_wb_oper = 1'b1; mu_wb_writereg = 1'b1; mu_wb_regdest = 5'd0;
        ls_wb_oper = 1'b0; ls_wb_writereg = 1'b1; ls_wb_regdest = 5'd9;
        step();
        expect_idle("s4.t0");
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        expect_idle("s4.t1");
        check("s4.rd_hold", 32'(wb_rf_regdest), 32'd7);
        check("s4.wd_hold", wb_rf_writedata, val(5'd7));
        step();
        expect_idle("s4.t2");

        // mu overfills under am/ls contention; dropped entry (r22) never written.
        for (int k = 0; k < 14; k++) begin
            if (k < 3)      drive(3'b111, 5'(10 + k), 5'(16 + k), 5'(24 + k));
            else if (k < 7) drive(3'b010, 5'd0, 5'(16 + k), 5'd0);
            else            drive(3'b000, 5'd0, 5'd0, 5'd0);
            step();
            if (k >= 1 && k <= 12) expect_wr($sformatf("s5_k%0d", k), s5_exp[k-1]);
            else                   expect_idle($sformatf("s5_k%0d", k));
            if (k == 1) check("s5.stall_k1", 32'(wb_iss_stall), 32'd0);
            if (k == 2) check("s5.stall_k2", 32'(wb_iss_stall), 32'd1);
            if (k == 5) check("s5.ovf_k5", 32'(wb_err_overflow), 32'd0);
            if (k == 6) check("s5.ovf_k6", 32'(wb_err_overflow), 32'd1);
        end
        check("s5.ovf_sticky", 32'(wb_err_overflow), 32'd1);

        // Reset with queues loaded: outputs clear at once, nothing drains afterwards.
        drive(3'b111, 5'd1, 5'd2, 5'd3);
        step();
        expect_idle("s6.t0");
        drive(3'b111, 5'd4, 5'd5, 5'd6);
        step();
        expect_wr("s6.t1", 5'd3);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        check("s6.we",  32'(wb_rf_writeenable), 32'd0);
        check("s6.rd",  32'(wb_rf_regdest), 32'd0);
        check("s6.wd",  wb_rf_writedata, 32'd0);
        check("s6.stl", 32'(wb_iss_stall), 32'd0);
        check("s6.ovf", 32'(wb_err_overflow), 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_idle($sformatf("s6_post_k%0d", k));
            check($sformatf("s6_post_stl_k%0d", k), 32'(wb_iss_stall), 32'd0);
        end
        single_am_push("s6r");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
